// File: rtl/crate_reg_bridge.sv
// Per-crate Wishbone register bridge. A classic-Wishbone register access is
// forwarded to the crate transport as one request/response transaction. The
// access can also be answered locally by a loopback register, or refused with
// dead data when the bridge is disabled or reserved. Timeouts, refusals and
// response errors are reported as one-cycle pulses.
module crate_reg_bridge #(
  parameter int          NUM_ADDRESS_BITS = 20,
  parameter int          TIMEOUT_CYCLES   = 1024,
  parameter logic [31:0] DEAD_DATA        = 32'hDEADBEEF
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [NUM_ADDRESS_BITS-1:0] wb_adr_i,
  input  logic [31:0]                 wb_dat_i,
  input  logic [3:0]                  wb_sel_i,
  output logic [31:0]                 wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic                        wb_rty_o,
  input  logic [1:0]                  bridge_type_i,
  output logic                        txn_valid_o,
  input  logic                        txn_ready_i,
  output logic                        txn_we_o,
  output logic [NUM_ADDRESS_BITS-1:0] txn_adr_o,
  output logic [31:0]                 txn_dat_o,
  output logic [3:0]                  txn_sel_o,
  input  logic                        rsp_valid_i,
  input  logic [31:0]                 rsp_dat_i,
  input  logic                        rsp_err_i,
  output logic                        timeout_o,
  output logic                        invalid_o
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   loop_reg;
  logic [31:0]   loop_next;
  logic          ack_flag;

  // Loopback register contents after merging the current write by byte select.
  always_comb begin
    loop_next = loop_reg;
    for (int b = 0; b < 4; b++) begin
      if (wb_sel_i[b]) loop_next[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
  end

  // Access sequencer: accept, forward or answer locally, wait, acknowledge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      loop_reg    <= '0;
      ack_flag    <= 1'b0;
      wb_dat_o    <= '0;
      txn_valid_o <= 1'b0;
      txn_we_o    <= 1'b0;
      txn_adr_o   <= '0;
      txn_dat_o   <= '0;
      txn_sel_o   <= '0;
      timeout_o   <= 1'b0;
      invalid_o   <= 1'b0;
    end else begin
      ack_flag  <= 1'b0;
      timeout_o <= 1'b0;
      invalid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            txn_we_o  <= wb_we_i;
            txn_adr_o <= wb_adr_i;
            txn_dat_o <= wb_dat_i;
            txn_sel_o <= wb_sel_i;
            tmo_cnt   <= '0;
            case (bridge_type_i)
              2'd1: begin
                txn_valid_o <= 1'b1;
                state       <= S_ISSUE;
              end
              2'd3: begin
                if (wb_we_i) loop_reg <= loop_next;
                else         wb_dat_o <= loop_reg;
                ack_flag <= 1'b1;
                state    <= S_ACK;
              end
              default: begin
                wb_dat_o  <= DEAD_DATA;
                invalid_o <= 1'b1;
                ack_flag  <= 1'b1;
                state     <= S_ACK;
              end
            endcase
          end
        end
        S_ISSUE: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (tmo_cnt == CNT_LAST) begin
            txn_valid_o <= 1'b0;
            wb_dat_o    <= DEAD_DATA;
            timeout_o   <= 1'b1;
            ack_flag    <= 1'b1;
            state       <= S_ACK;
          end else if (txn_ready_i) begin
            txn_valid_o <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (rsp_valid_i) begin
            wb_dat_o  <= rsp_err_i ? DEAD_DATA : rsp_dat_i;
            invalid_o <= rsp_err_i;
            ack_flag  <= 1'b1;
            state     <= S_ACK;
          end else if (tmo_cnt == CNT_LAST) begin
            wb_dat_o  <= DEAD_DATA;
            timeout_o <= 1'b1;
            ack_flag  <= 1'b1;
            state     <= S_ACK;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_ack_o = ack_flag & wb_cyc_i;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_crate_reg_bridge.sv
// Bench for crate_reg_bridge: each access is described at transaction level,
// the expected ack cycle, data, pulses and request window are computed from
// plain cycle arithmetic, and one process compares the outputs every cycle.
module tb_crate_reg_bridge;

  localparam int          AW      = 20;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] DEAD    = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_rty_o;
  logic [1:0]    bridge_type_i;
  logic          txn_valid_o, txn_ready_i, txn_we_o;
  logic [AW-1:0] txn_adr_o;
  logic [31:0]   txn_dat_o;
  logic [3:0]    txn_sel_o;
  logic          rsp_valid_i, rsp_err_i;
  logic [31:0]   rsp_dat_i;
  logic          timeout_o, invalid_o;

  crate_reg_bridge #(
    .NUM_ADDRESS_BITS(AW),
    .TIMEOUT_CYCLES  (TIMEOUT),
    .DEAD_DATA       (DEAD)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_i     (wb_sel_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .wb_err_o     (wb_err_o),
    .wb_rty_o     (wb_rty_o),
    .bridge_type_i(bridge_type_i),
    .txn_valid_o  (txn_valid_o),
    .txn_ready_i  (txn_ready_i),
    .txn_we_o     (txn_we_o),
    .txn_adr_o    (txn_adr_o),
    .txn_dat_o    (txn_dat_o),
    .txn_sel_o    (txn_sel_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_dat_i    (rsp_dat_i),
    .rsp_err_i    (rsp_err_i),
    .timeout_o    (timeout_o),
    .invalid_o    (invalid_o)
  );

  typedef struct {
    int          cyc;
    bit          ack;
    bit          chk_data;
    logic [31:0] data;
    bit          tmo;
    bit          inv;
  } expect_t;

  expect_t       exp_q[$];
  expect_t       cur_exp;
  int            cycle_no = 0;
  int            tests_run = 0;
  int            tests_failed = 0;
  bit            model_on = 1'b0;
  int            v_from = 1;
  int            v_to = 0;
  logic          v_we;
  logic [AW-1:0] v_adr;
  logic [31:0]   v_dat;
  logic [3:0]    v_sel;
  logic [31:0]   loop_model = '0;
  int            last_start = 0;
  int            obs_ack_cycle = -1;
  int            obs_tmo_cycle = -1;
  int            obs_inv_cycle = -1;
  logic [31:0]   obs_ack_data = '0;

  // Free-running clock and cycle index.
  initial forever #5 clk = ~clk;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle_no);
    end
  endtask

  // Per-cycle comparison against the transaction model, on the falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cycle_no) void'(exp_q.pop_front());
      cur_exp = '{cyc: cycle_no, ack: 1'b0, chk_data: 1'b0, data: 32'h0, tmo: 1'b0, inv: 1'b0};
      if (exp_q.size() > 0 && exp_q[0].cyc == cycle_no) cur_exp = exp_q[0];
      checkOutput("wb_ack", 32'(wb_ack_o), 32'(cur_exp.ack));
      checkOutput("timeout", 32'(timeout_o), 32'(cur_exp.tmo));
      checkOutput("invalid", 32'(invalid_o), 32'(cur_exp.inv));
      checkOutput("err_rty", 32'({wb_err_o, wb_rty_o}), 32'd0);
      if (cur_exp.chk_data) checkOutput("wb_dat", wb_dat_o, cur_exp.data);
      if (cycle_no >= v_from && cycle_no <= v_to) begin
        checkOutput("txn_valid", 32'(txn_valid_o), 32'd1);
        checkOutput("txn_we", 32'(txn_we_o), 32'(v_we));
        checkOutput("txn_adr", 32'(txn_adr_o), 32'(v_adr));
        checkOutput("txn_dat", txn_dat_o, v_dat);
        checkOutput("txn_sel", 32'(txn_sel_o), 32'(v_sel));
      end else begin
        checkOutput("txn_valid", 32'(txn_valid_o), 32'd0);
      end
      if (wb_ack_o) begin
        obs_ack_cycle = cycle_no;
        obs_ack_data  = wb_dat_o;
      end
      if (timeout_o) obs_tmo_cycle = cycle_no;
      if (invalid_o) obs_inv_cycle = cycle_no;
    end
  end

  // One complete access: model expectations, then drive it cycle by cycle.
  task automatic applyStimulus(input bit we, input logic [AW-1:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [1:0] btype,
                               input int ready_dly, input int rsp_dly, input bit rsp_err,
                               input logic [31:0] rsp_data, input bit drop_cyc,
                               input bit change_type, input int stray_off);
    int n, h, r, e, a, last, c;
    expect_t ev;
    n = cycle_no;
    last_start = n;
    obs_ack_cycle = -1;
    obs_tmo_cycle = -1;
    obs_inv_cycle = -1;
    obs_ack_data  = '0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; bridge_type_i = btype;
    ev = '{cyc: n + 1, ack: 1'b1, chk_data: 1'b0, data: 32'h0, tmo: 1'b0, inv: 1'b0};
    h = -1; r = -1; e = n + TIMEOUT;
    case (btype)
      2'd1: begin
        v_we = we; v_adr = adr; v_dat = dat; v_sel = sel;
        if (ready_dly < TIMEOUT - 1) h = n + 1 + ready_dly;
        if (h >= 0 && rsp_dly >= 0) r = h + 1 + rsp_dly;
        v_from = n + 1;
        v_to   = (h < 0) ? e : h;
        if (r >= 0 && r <= e) begin
          ev.cyc = r + 1; ev.chk_data = !we;
          ev.data = rsp_err ? DEAD : rsp_data; ev.inv = rsp_err;
        end else begin
          ev.cyc = e + 1; ev.chk_data = !we; ev.data = DEAD; ev.tmo = 1'b1;
        end
      end
      2'd3: begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (sel[b]) loop_model[8*b +: 8] = dat[8*b +: 8];
        end else begin
          ev.chk_data = 1'b1; ev.data = loop_model;
        end
      end
      default: begin
        ev.chk_data = !we; ev.data = DEAD; ev.inv = 1'b1;
      end
    endcase
    ev.ack = !drop_cyc;
    exp_q.push_back(ev);
    a = ev.cyc;
    last = a + 1;
    if (stray_off > 0 && n + stray_off + 1 > last) last = n + stray_off + 1;
    while (cycle_no < last) begin
      @(posedge clk); #1;
      c = cycle_no;
      if (c == a + 1) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      if (drop_cyc && h >= 0 && c == h + 1) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      if (change_type && h >= 0 && c == h + 1) bridge_type_i = 2'd0;
      txn_ready_i = (c == h);
      rsp_valid_i = (c == r) || (stray_off > 0 && c == n + stray_off);
      rsp_err_i   = (c == r) && rsp_err;
      rsp_dat_i   = (c == r) ? rsp_data : ((stray_off > 0 && c == n + stray_off) ? 32'h11111111 : 32'h0);
    end
    v_from = 1; v_to = 0;
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    bridge_type_i = 0; txn_ready_i = 0; rsp_valid_i = 0; rsp_err_i = 0; rsp_dat_i = '0;
    #1;
    checkOutput("rst_valid", 32'(txn_valid_o), 32'd0);
    checkOutput("rst_ack", 32'(wb_ack_o), 32'd0);
    checkOutput("rst_dat", wb_dat_o, 32'd0);
    checkOutput("rst_adr", 32'(txn_adr_o), 32'd0);
    checkOutput("rst_pulses", 32'({timeout_o, invalid_o}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_on = 1'b1;
    @(posedge clk); #1;

    // Disabled bridge refuses the read.
    applyStimulus(0, 20'h00100, 32'h0, 4'hF, 2'd0, 0, -1, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_t0_latency", 32'(obs_ack_cycle - last_start), 32'd1);
    checkOutput("lit_t0_data", obs_ack_data, 32'hDEADBEEF);
    checkOutput("lit_t0_invalid", 32'(obs_inv_cycle - last_start), 32'd1);

    // Loopback partial write then read back.
    applyStimulus(1, 20'h00104, 32'h12345678, 4'b0011, 2'd3, 0, -1, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_lb_wr_latency", 32'(obs_ack_cycle - last_start), 32'd1);
    applyStimulus(0, 20'h00104, 32'h0, 4'hF, 2'd3, 0, -1, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_lb_rd_data", obs_ack_data, 32'h00005678);

    // Transport read with a 3-cycle stall, response 2 cycles after handshake.
    applyStimulus(0, 20'h00200, 32'h0, 4'hF, 2'd1, 3, 1, 0, 32'hCAFE0001, 0, 0, 0);
    checkOutput("lit_tr_data", obs_ack_data, 32'hCAFE0001);
    checkOutput("lit_tr_latency", 32'(obs_ack_cycle - last_start), 32'd7);

    // Never accepted, never answered: withdrawn on timeout, late response ignored.
    applyStimulus(0, 20'h00300, 32'h0, 4'hF, 2'd1, 100, -1, 0, 32'h0, 0, 0, 20);
    checkOutput("lit_tmo_latency", 32'(obs_ack_cycle - last_start), 32'd17);
    checkOutput("lit_tmo_pulse", 32'(obs_tmo_cycle - last_start), 32'd17);
    checkOutput("lit_tmo_data", obs_ack_data, 32'hDEADBEEF);

    // Error response.
    applyStimulus(0, 20'h00400, 32'h0, 4'hF, 2'd1, 0, 0, 1, 32'h55555555, 0, 0, 0);
    checkOutput("lit_err_invalid", 32'(obs_inv_cycle - last_start), 32'd3);
    checkOutput("lit_err_data", obs_ack_data, 32'hDEADBEEF);

    // Response on the expiry cycle wins over the timeout.
    applyStimulus(0, 20'h00500, 32'h0, 4'hF, 2'd1, 1, 13, 0, 32'h0BADF00D, 0, 0, 0);
    checkOutput("lit_expiry_data", obs_ack_data, 32'h0BADF00D);
    checkOutput("lit_expiry_no_tmo", 32'(obs_tmo_cycle), 32'hFFFFFFFF);

    // Bridge type changes during the wait; the access still uses the transport.
    applyStimulus(0, 20'h00600, 32'h0, 4'hF, 2'd1, 0, 2, 0, 32'h600DCAFE, 0, 1, 0);
    checkOutput("lit_type_change_data", obs_ack_data, 32'h600DCAFE);

    // Master abort during the wait: no ack is seen.
    applyStimulus(1, 20'h00700, 32'hA5A5A5A5, 4'b1010, 2'd1, 0, 3, 0, 32'h0, 1, 0, 0);
    checkOutput("lit_abort_no_ack", 32'(obs_ack_cycle), 32'hFFFFFFFF);

    // Reserved type write, more loopback, transport write.
    applyStimulus(1, 20'h00800, 32'h01010101, 4'hF, 2'd2, 0, -1, 0, 32'h0, 0, 0, 0);
    applyStimulus(1, 20'h00104, 32'hAABBCCDD, 4'b1100, 2'd3, 0, -1, 0, 32'h0, 0, 0, 0);
    applyStimulus(0, 20'h00104, 32'h0, 4'hF, 2'd3, 0, -1, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_lb_merge", obs_ack_data, 32'hAABB5678);
    applyStimulus(1, 20'hFFFFC, 32'h01020304, 4'hF, 2'd1, 2, 0, 0, 32'h0, 0, 0, 0);

    // Asynchronous reset while a request is being issued.
    model_on = 1'b0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 20'h00900; bridge_type_i = 2'd1;
    txn_ready_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("lit_issue_valid", 32'(txn_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(txn_valid_o), 32'd0);
    checkOutput("async_rst_adr", 32'(txn_adr_o), 32'd0);
    wb_cyc_i = 0; wb_stb_i = 0; bridge_type_i = 2'd0;
    exp_q.delete();
    loop_model = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_on = 1'b1;
    applyStimulus(0, 20'h00104, 32'h0, 4'hF, 2'd3, 0, -1, 0, 32'h0, 0, 0, 0);
    checkOutput("lit_post_rst_loop", obs_ack_data, 32'h00000000);
    applyStimulus(0, 20'h00A00, 32'h0, 4'hF, 2'd1, 1, 1, 0, 32'h13572468, 0, 0, 0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/crate_reg_bridge.md
Name: crate_reg_bridge

Overview:
- Per-crate Wishbone register bridge. Takes classic-Wishbone register accesses aimed at one crate and forwards them to the crate transport as a request/response transaction.
- Four instances sit downstream of the ID/control block. Each consumes its 2-bit bridge-type field and returns the timeout and invalid event pulses that the control block latches as sticky status.

Parameters:
- NUM_ADDRESS_BITS, 20, width of the Wishbone byte address forwarded to the crate.
- TIMEOUT_CYCLES, 1024, cycles allowed from request accept to response before the access is abandoned (minimum 4).
- DEAD_DATA, 32'hDEADBEEF, read data returned on a disabled, timed-out or errored access.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i / wb_stb_i / wb_we_i  in  1 each  Wishbone target controls
- wb_adr_i  in  NUM_ADDRESS_BITS  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  access acknowledge
- wb_err_o / wb_rty_o  out  1 each  tied 0
- bridge_type_i  in  2  0=disabled, 1=transport, 2=reserved, 3=local loopback
- txn_valid_o  out  1  transport request valid
- txn_ready_i  in  1  transport request accept
- txn_we_o  out  1  request write flag
- txn_adr_o  out  NUM_ADDRESS_BITS  request address
- txn_dat_o  out  32  request write data
- txn_sel_o  out  4  request byte selects
- rsp_valid_i  in  1  response strobe, single cycle
- rsp_dat_i  in  32  response read data
- rsp_err_i  in  1  response error flag, qualified by rsp_valid_i
- timeout_o  out  1  one-cycle pulse on timeout
- invalid_o  out  1  one-cycle pulse on disabled/reserved access or response error

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0, including wb_dat_o=0, txn_* =0.
  - Loopback register=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE, on a cycle with cyc&stb (the accept cycle, N):
  - Capture we, adr, dat and sel into the txn_* registers.
  - Sample bridge_type_i. The sampled type governs the whole access; later changes to bridge_type_i are ignored until the next IDLE.
  - Clear the timeout counter.
- IDLE next-state by sampled type:
  - type 0 or 2: go to ACK with wb_dat_o=DEAD_DATA; pulse invalid_o in cycle N+1.
  - type 3 (local loopback): go to ACK. A write updates the loopback register per byte select; a read returns the loopback register.
  - type 1 (transport): go to ISSUE; txn_valid_o=1 from cycle N+1.
- ISSUE:
  - txn_valid_o holds 1 with stable payload until the cycle where txn_valid_o&txn_ready_i is true.
  - On that handshake: txn_valid_o=0 next cycle, go to WAIT.
- WAIT:
  - On rsp_valid_i: wb_dat_o = rsp_err_i ? DEAD_DATA : rsp_dat_i; go to ACK.
  - If rsp_err_i was set, pulse invalid_o on the ACK cycle.
- Timeout counter:
  - Increments every cycle spent in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without a response: txn_valid_o=0 (the request is withdrawn even without ready), wb_dat_o=DEAD_DATA, go to ACK, pulse timeout_o on the ACK cycle.
  - The ack therefore lands at cycle N+1+TIMEOUT_CYCLES.
  - If rsp_valid_i arrives on the expiry cycle, the response wins and no timeout is signalled.
- ACK:
  - Internal ack flag=1 for exactly one cycle, then IDLE.
  - wb_ack_o = ack flag & wb_cyc_i.
  - A new access may be accepted in the IDLE cycle after ACK.
- Latency:
  - Types 0/2/3: ack in cycle N+1.
  - Type 1: ack one cycle after the rsp_valid_i cycle.
- Master abort (wb_cyc_i drops mid-access):
  - The FSM still completes its handshake, response wait or timeout.
  - The ack is masked by wb_cyc_i.
  - Status pulses still fire.
- Stray responses: rsp_valid_i outside WAIT (late after a timeout, or unsolicited) is discarded with no pulse.
- Pulse exclusivity: timeout_o and invalid_o are never high together.
- wb_dat_o: updated only on the transition into ACK, held otherwise.

Test Plan:
- type=0, read 0x00100 -> ack at N+1, wb_dat_o=0xDEADBEEF, invalid_o single pulse, txn_valid_o never asserted.
- type=3: write 0x12345678 with sel=4'b0011, then read -> read returns 0x00005678; both acks at N+1.
- type=1, txn_ready_i held low 3 cycles, rsp_valid_i 2 cycles after the handshake with 0xCAFE0001 -> txn_valid_o/adr stable throughout the stall, ack one cycle after rsp, data 0xCAFE0001, no pulses.
- TIMEOUT_CYCLES=16, type=1, no response -> txn_valid_o drops, ack at N+17 with 0xDEADBEEF, timeout_o pulse; a rsp_valid_i at N+20 is ignored.
- Edge cases:
  - rsp_valid_i with rsp_err_i=1 -> DEAD_DATA and invalid_o.
  - rsp_valid_i exactly on the expiry cycle -> response data, no timeout_o.
  - bridge_type_i changed 1->0 during WAIT -> access still completes via transport.
- wb_cyc_i dropped during WAIT -> no wb_ack_o. Separately, wb_rst_i asserted mid-ISSUE -> txn_valid_o low immediately (asynchronously), state IDLE, next access normal.
